char_feeder: RTL

//  Upstream stage for synchro: buffers 8-bit characters from a host-side valid/ready stream
//  in a DEPTH-entry FIFO and issues them to synchro one at a time as single-cycle write pulses.

---
 rtl/char_feeder_if.sv | 45 ++++
 rtl/char_feeder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/char_feeder_if.sv
// Bundle of the host-side character stream and the synchro-side write port
// seen by char_feeder. The master modport is the host/environment view, the
// slave modport is the feeder's own view.
interface char_feeder_if #(
    parameter int AW = 4
);
    // Host stream (valid/ready)
    logic          in_valid;
    logic [7:0]    in_char;
    logic          in_ready;

    // Synchro side
    logic          full;
    logic          o_write;
    logic [7:0]    o_char;

    // Status
    logic [AW:0]   count;
    logic [15:0]   sent;
    logic          busy;

    modport master (
        output in_valid,
        output in_char,
        output full,
        input  in_ready,
        input  o_write,
        input  o_char,
        input  count,
        input  sent,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_char,
        input  full,
        output in_ready,
        output o_write,
        output o_char,
        output count,
        output sent,
        output busy
    );
endinterface

// File: rtl/char_feeder.sv
// char_feeder: buffers host characters in a small FIFO and hands them to
// synchro as single-cycle write pulses, spaced by GAP idle cycles and held
// off while synchro reports full. Also counts characters delivered.
module char_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int GAP   = 200
) (
    input  logic          clk,
    input  logic          rst,
    char_feeder_if.slave  bus
);

    // Width of the idle-gap down-counter; at least one bit so GAP=0 builds.
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    // Value loaded when entering HOLD; only reachable when GAP > 0.
    localparam logic [GW-1:0] GAP_RELOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    // Occupancy value meaning "FIFO full".
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   gap_q;
    logic [GW-1:0]   gap_d;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count_q;

    logic            o_write_q;
    logic [7:0]      o_char_q;
    logic [15:0]     sent_q;

    logic            push;
    logic            pop;
    logic            write_d;

    // A push only depends on the registered occupancy, so a full FIFO refuses
    // data even when a pop happens on the same edge.
    always_comb begin
        push = bus.in_valid && (count_q != DEPTH_C);
    end

    // Next-state logic: issue from IDLE when data is waiting and synchro is
    // not full, spend one cycle in ISSUE, then sit out GAP cycles in HOLD.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !bus.full) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                    write_d = 1'b1;
                end
            end
            ISSUE: begin
                if (GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                    gap_d   = GAP_RELOAD;
                end
            end
            HOLD: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and gap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_char;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is 2**AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered write strobe, held character and delivered-character count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_write_q <= 1'b0;
            o_char_q  <= '0;
            sent_q    <= '0;
        end else begin
            o_write_q <= write_d;
            if (pop) begin
                o_char_q <= mem[rd_ptr];
                sent_q   <= sent_q + 16'd1;
            end
        end
    end

    // Output drive onto the interface.
    always_comb begin
        bus.in_ready = (count_q != DEPTH_C);
        bus.o_write  = o_write_q;
        bus.o_char   = o_char_q;
        bus.count    = count_q;
        bus.sent     = sent_q;
        bus.busy     = (count_q != '0) || (state_q != IDLE);
    end

endmodule
